arc_windowed_regfile: RTL and testbench

Parametrised ARC register file with SPARC-style overlapping register windows, replacing the fixed 16-register bank in the datapath. It holds globals, `NWIN` windows of in/local/out registers, PC, four temporaries and IR. It drives two combinational read buses (A, B) and takes one write port from bus C. A current-window pointer (CWP) with occupancy tracking implements `save`/`restore` and flags overflow and underflow traps to the control unit.

---
 rtl/arc_regfile_pkg.sv | 30 +++
 rtl/regwin_map.sv | 46 ++++
 rtl/arc_windowed_regfile.sv | 173 +++++++++++++++++
 tb/tb_arc_windowed_regfile.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/arc_regfile_pkg.sv
// Shared address map and region encoding for the windowed ARC register file.
package arc_regfile_pkg;

    localparam logic [5:0] ADDR_ZERO   = 6'd0;
    localparam logic [5:0] ADDR_G_BASE = 6'd1;
    localparam logic [5:0] ADDR_O_BASE = 6'd8;
    localparam logic [5:0] ADDR_L_BASE = 6'd16;
    localparam logic [5:0] ADDR_I_BASE = 6'd24;
    localparam logic [5:0] ADDR_PC     = 6'd32;
    localparam logic [5:0] ADDR_T0     = 6'd33;
    localparam logic [5:0] ADDR_IR     = 6'd37;

    // PC, temp0..3 and IR live in one small bank indexed from ADDR_PC.
    localparam int NSPECIAL = int'(ADDR_IR - ADDR_PC) + 1;
    localparam int IR_SLOT  = int'(ADDR_IR - ADDR_PC);

    typedef enum logic [2:0] {
        ZERO,
        GLOBAL,
        WIN,
        SPECIAL,
        NONE
    } region_e;

    // True for regions that are backed by real storage.
    function automatic logic is_storage(region_e r);
        return (r == GLOBAL) || (r == WIN) || (r == SPECIAL);
    endfunction

endpackage

// File: rtl/regwin_map.sv
// Logical-to-physical address translator: one 6-bit logical address plus
// the current window pointer gives a storage region and an index within it.
module regwin_map
    import arc_regfile_pkg::*;
#(
    parameter int NWIN = 4,
    localparam int CW  = $clog2(NWIN),
    localparam int IW  = CW + 4
) (
    input  logic [5:0]    i_addr,
    input  logic [CW-1:0] i_cwp,
    output region_e       o_region,
    output logic [IW-1:0] o_idx
);

    logic [CW-1:0] w_cwp_next;

    // Outs of window w are stored as the ins of window w+1; the CW-bit add
    // wraps naturally because NWIN is a power of two.
    assign w_cwp_next = i_cwp + CW'(1);

    // Decode region; window slots are {window, in=0/local=1, offset}.
    always_comb begin
        o_region = NONE;
        o_idx    = '0;
        if (i_addr == ADDR_ZERO) begin
            o_region = ZERO;
        end else if (i_addr < ADDR_O_BASE) begin
            o_region = GLOBAL;
            o_idx    = IW'(i_addr[2:0]);
        end else if (i_addr < ADDR_L_BASE) begin
            o_region = WIN;
            o_idx    = {w_cwp_next, 1'b0, i_addr[2:0]};
        end else if (i_addr < ADDR_I_BASE) begin
            o_region = WIN;
            o_idx    = {i_cwp, 1'b1, i_addr[2:0]};
        end else if (i_addr < ADDR_PC) begin
            o_region = WIN;
            o_idx    = {i_cwp, 1'b0, i_addr[2:0]};
        end else if (i_addr <= ADDR_IR) begin
            o_region = SPECIAL;
            o_idx    = IW'(i_addr[2:0] - ADDR_PC[2:0]);
        end
    end

endmodule

// File: rtl/arc_windowed_regfile.sv
// ARC register file with overlapping SPARC-style windows, two combinational
// read buses, one write port, and save/restore window management with
// overflow/underflow trap pulses.
module arc_windowed_regfile
    import arc_regfile_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NWIN   = 4,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              ra_addr,
    input  logic [5:0]              rb_addr,
    input  logic [5:0]              rc_addr,
    input  logic                    wr_en,
    input  logic [DW-1:0]           wr_data,
    input  logic                    save,
    input  logic                    restore,
    input  logic                    win_clr,
    output logic [DW-1:0]           bus_a,
    output logic [DW-1:0]           bus_b,
    output logic [DW-1:0]           ir,
    output logic [$clog2(NWIN)-1:0] cwp,
    output logic                    ovf_trap,
    output logic                    unf_trap
);

    localparam int CW    = $clog2(NWIN);
    localparam int IW    = CW + 4;
    localparam int NPHYS = NWIN * 16;

    logic [DW-1:0] r_win  [NPHYS];
    logic [DW-1:0] r_glob [1:7];
    logic [DW-1:0] r_spec [NSPECIAL];

    logic [CW-1:0] r_cwp;
    logic [CW-1:0] r_resident;
    logic          r_ovf;
    logic          r_unf;

    logic [CW-1:0] w_cwp_nxt;
    logic [CW-1:0] w_resident_nxt;
    logic          w_ovf_nxt;
    logic          w_unf_nxt;

    region_e       w_reg_a;
    region_e       w_reg_b;
    region_e       w_reg_c;
    logic [IW-1:0] w_idx_a;
    logic [IW-1:0] w_idx_b;
    logic [IW-1:0] w_idx_c;
    logic          w_hit_a;
    logic          w_hit_b;

    regwin_map #(.NWIN(NWIN)) u_map_a (
        .i_addr   (ra_addr),
        .i_cwp    (r_cwp),
        .o_region (w_reg_a),
        .o_idx    (w_idx_a)
    );

    regwin_map #(.NWIN(NWIN)) u_map_b (
        .i_addr   (rb_addr),
        .i_cwp    (r_cwp),
        .o_region (w_reg_b),
        .o_idx    (w_idx_b)
    );

    // The write decode uses the current (pre-save/restore) window pointer.
    regwin_map #(.NWIN(NWIN)) u_map_c (
        .i_addr   (rc_addr),
        .i_cwp    (r_cwp),
        .o_region (w_reg_c),
        .o_idx    (w_idx_c)
    );

    // Same physical register as the write port; mapping both sides through
    // the translator makes window-overlap aliases compare equal.
    assign w_hit_a = (BYPASS != 0) && wr_en && is_storage(w_reg_c) &&
                     (w_reg_a == w_reg_c) && (w_idx_a == w_idx_c);
    assign w_hit_b = (BYPASS != 0) && wr_en && is_storage(w_reg_c) &&
                     (w_reg_b == w_reg_c) && (w_idx_b == w_idx_c);

    // Register storage: cleared on reset, one write per cycle from bus C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPHYS; i++) r_win[i] <= '0;
            for (int i = 1; i < 8; i++) r_glob[i] <= '0;
            for (int i = 0; i < NSPECIAL; i++) r_spec[i] <= '0;
        end else if (wr_en) begin
            case (w_reg_c)
                GLOBAL:  r_glob[w_idx_c[2:0]] <= wr_data;
                WIN:     r_win[w_idx_c]       <= wr_data;
                SPECIAL: r_spec[w_idx_c[2:0]] <= wr_data;
                default: ;
            endcase
        end
    end

    // Read bus A with optional same-cycle forwarding of the write data.
    always_comb begin
        bus_a = '0;
        case (w_reg_a)
            GLOBAL:  bus_a = r_glob[w_idx_a[2:0]];
            WIN:     bus_a = r_win[w_idx_a];
            SPECIAL: bus_a = r_spec[w_idx_a[2:0]];
            default: bus_a = '0;
        endcase
        if (w_hit_a) bus_a = wr_data;
    end

    // Read bus B with optional same-cycle forwarding of the write data.
    always_comb begin
        bus_b = '0;
        case (w_reg_b)
            GLOBAL:  bus_b = r_glob[w_idx_b[2:0]];
            WIN:     bus_b = r_win[w_idx_b];
            SPECIAL: bus_b = r_spec[w_idx_b[2:0]];
            default: bus_b = '0;
        endcase
        if (w_hit_b) bus_b = wr_data;
    end

    assign ir = r_spec[IR_SLOT];

    // Window next-state: clear wins, a simultaneous save+restore is a no-op,
    // and a save/restore that would exceed the resident range traps instead.
    always_comb begin
        w_cwp_nxt      = r_cwp;
        w_resident_nxt = r_resident;
        w_ovf_nxt      = 1'b0;
        w_unf_nxt      = 1'b0;
        if (win_clr) begin
            w_cwp_nxt      = '0;
            w_resident_nxt = CW'(1);
        end else if (save && !restore) begin
            if (r_resident == CW'(NWIN - 1)) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cwp_nxt      = r_cwp + CW'(1);
                w_resident_nxt = r_resident + CW'(1);
            end
        end else if (restore && !save) begin
            if (r_resident == CW'(1)) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_cwp_nxt      = r_cwp - CW'(1);
                w_resident_nxt = r_resident - CW'(1);
            end
        end
    end

    // Window state and trap pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cwp      <= '0;
            r_resident <= CW'(1);
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_cwp      <= w_cwp_nxt;
            r_resident <= w_resident_nxt;
            r_ovf      <= w_ovf_nxt;
            r_unf      <= w_unf_nxt;
        end
    end

    assign cwp      = r_cwp;
    assign ovf_trap = r_ovf;
    assign unf_trap = r_unf;

endmodule

// File: tb/tb_arc_windowed_regfile.sv
// Directed self-checking bench for arc_windowed_regfile (NWIN=4), running a
// forwarding instance and a non-forwarding instance side by side.
module tb_arc_windowed_regfile;

    logic        clk;
    logic        rst;
    logic [5:0]  ra_addr;
    logic [5:0]  rb_addr;
    logic [5:0]  rc_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        save;
    logic        restore;
    logic        win_clr;

    logic [31:0] bus_a, bus_b, ir;
    logic [1:0]  cwp;
    logic        ovf_trap, unf_trap;

    logic [31:0] nb_bus_a, nb_bus_b, nb_ir;
    logic [1:0]  nb_cwp;
    logic        nb_ovf_trap, nb_unf_trap;

    int total = 0;
    int bad   = 0;

    arc_windowed_regfile #(.DW(32), .NWIN(4), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .rc_addr(rc_addr), .wr_en(wr_en), .wr_data(wr_data), .save(save),
        .restore(restore), .win_clr(win_clr), .bus_a(bus_a), .bus_b(bus_b),
        .ir(ir), .cwp(cwp), .ovf_trap(ovf_trap), .unf_trap(unf_trap)
    );

    arc_windowed_regfile #(.DW(32), .NWIN(4), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .rc_addr(rc_addr), .wr_en(wr_en), .wr_data(wr_data), .save(save),
        .restore(restore), .win_clr(win_clr), .bus_a(nb_bus_a), .bus_b(nb_bus_b),
        .ir(nb_ir), .cwp(nb_cwp), .ovf_trap(nb_ovf_trap), .unf_trap(nb_unf_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; save = 0; restore = 0; win_clr = 0;
        rc_addr = 0; wr_data = 0; ra_addr = 0; rb_addr = 0;
    endtask

    task automatic test_reset();
        // Put some state in place, then drop reset in the middle of a write.
        wr_en = 1; rc_addr = 6'd1;  wr_data = 32'h55; tick();
        rc_addr = 6'd33; wr_data = 32'h66; tick();
        rc_addr = 6'd37; wr_data = 32'h77; tick();
        wr_en = 0; save = 1; tick();
        save = 0;
        wr_en = 1; rc_addr = 6'd1; wr_data = 32'h99;
        #2 rst = 0;
        #1;
        total++; if (cwp !== 2'd0) begin $display("FAIL reset_cwp got=%0d want=0", cwp); bad++; end
        total++; if (ovf_trap !== 1'b0 || unf_trap !== 1'b0) begin
            $display("FAIL reset_traps got=%b%b want=00", ovf_trap, unf_trap); bad++; end
        total++; if (ir !== 32'h0) begin $display("FAIL reset_ir got=%h want=0", ir); bad++; end
        wr_en = 0;
        for (int a = 0; a < 64; a++) begin
            ra_addr = 6'(a);
            #1;
            total++;
            if (bus_a !== 32'h0) begin
                $display("FAIL reset_read addr=%0d got=%h want=0", a, bus_a); bad++;
            end
        end
        @(negedge clk);
        rst = 1;
        tick();
        total++; if (cwp !== 2'd0) begin $display("FAIL reset_release_cwp got=%0d want=0", cwp); bad++; end
    endtask

    task automatic test_overlap();
        wr_en = 1; rc_addr = 6'd8; wr_data = 32'hA5; tick();
        wr_en = 0; save = 1; tick();
        save = 0;
        total++; if (cwp !== 2'd1) begin $display("FAIL overlap_cwp got=%0d want=1", cwp); bad++; end
        ra_addr = 6'd24; rb_addr = 6'd16; #1;
        total++; if (bus_a !== 32'hA5) begin $display("FAIL overlap_in0 got=%h want=000000a5", bus_a); bad++; end
        total++; if (bus_b !== 32'h0) begin $display("FAIL overlap_local0 got=%h want=0", bus_b); bad++; end
        ra_addr = 6'd8; #1;
        total++; if (bus_a !== 32'h0) begin $display("FAIL overlap_out0_w1 got=%h want=0", bus_a); bad++; end
        win_clr = 1; tick();
        win_clr = 0;
        total++; if (cwp !== 2'd0) begin $display("FAIL winclr_cwp got=%0d want=0", cwp); bad++; end
        ra_addr = 6'd8; #1;
        total++; if (bus_a !== 32'hA5) begin $display("FAIL winclr_keeps_data got=%h want=000000a5", bus_a); bad++; end
    endtask

    task automatic test_overflow();
        save = 1; tick();
        total++; if (cwp !== 2'd1 || ovf_trap !== 1'b0) begin
            $display("FAIL ovf_save1 cwp=%0d ovf=%b want cwp=1 ovf=0", cwp, ovf_trap); bad++; end
        tick();
        total++; if (cwp !== 2'd2 || ovf_trap !== 1'b0) begin
            $display("FAIL ovf_save2 cwp=%0d ovf=%b want cwp=2 ovf=0", cwp, ovf_trap); bad++; end
        tick();
        save = 0;
        total++; if (ovf_trap !== 1'b1 || unf_trap !== 1'b0) begin
            $display("FAIL ovf_pulse got=%b%b want=10", ovf_trap, unf_trap); bad++; end
        total++; if (cwp !== 2'd2) begin $display("FAIL ovf_cwp_hold got=%0d want=2", cwp); bad++; end
        tick();
        total++; if (ovf_trap !== 1'b0) begin $display("FAIL ovf_single_cycle got=%b want=0", ovf_trap); bad++; end
        restore = 1; tick();
        total++; if (cwp !== 2'd1 || unf_trap !== 1'b0) begin
            $display("FAIL unf_rest1 cwp=%0d unf=%b want cwp=1 unf=0", cwp, unf_trap); bad++; end
        tick();
        total++; if (cwp !== 2'd0 || unf_trap !== 1'b0) begin
            $display("FAIL unf_rest2 cwp=%0d unf=%b want cwp=0 unf=0", cwp, unf_trap); bad++; end
        tick();
        restore = 0;
        total++; if (unf_trap !== 1'b1 || ovf_trap !== 1'b0) begin
            $display("FAIL unf_pulse got=%b%b want=01", ovf_trap, unf_trap); bad++; end
        total++; if (cwp !== 2'd0) begin $display("FAIL unf_cwp_hold got=%0d want=0", cwp); bad++; end
        tick();
        total++; if (unf_trap !== 1'b0) begin $display("FAIL unf_single_cycle got=%b want=0", unf_trap); bad++; end
    endtask

    task automatic test_bypass();
        ra_addr = 6'd34; rb_addr = 6'd34;
        wr_en = 1; rc_addr = 6'd34; wr_data = 32'h1234; #1;
        total++; if (bus_a !== 32'h1234) begin $display("FAIL bypass_same_cycle got=%h want=00001234", bus_a); bad++; end
        total++; if (bus_b !== 32'h1234) begin $display("FAIL bypass_bus_b got=%h want=00001234", bus_b); bad++; end
        total++; if (nb_bus_a !== 32'h0) begin $display("FAIL nobypass_old got=%h want=0", nb_bus_a); bad++; end
        tick();
        wr_en = 0; #1;
        total++; if (nb_bus_a !== 32'h1234) begin $display("FAIL nobypass_next got=%h want=00001234", nb_bus_a); bad++; end
        total++; if (bus_a !== 32'h1234) begin $display("FAIL bypass_stored got=%h want=00001234", bus_a); bad++; end
    endtask

    task automatic test_zero_unmapped();
        wr_en = 1; wr_data = 32'hFFFF_FFFF;
        rc_addr = 6'd0; ra_addr = 6'd0; #1;
        total++; if (bus_a !== 32'h0) begin $display("FAIL zero_no_bypass got=%h want=0", bus_a); bad++; end
        tick();
        rc_addr = 6'd50; ra_addr = 6'd50; #1;
        total++; if (bus_a !== 32'h0) begin $display("FAIL unmapped_no_bypass got=%h want=0", bus_a); bad++; end
        tick();
        wr_en = 0;
        ra_addr = 6'd0; rb_addr = 6'd50; #1;
        total++; if (bus_a !== 32'h0 || bus_b !== 32'h0) begin
            $display("FAIL zero_unmapped_read got=%h/%h want=0/0", bus_a, bus_b); bad++; end
        ra_addr = 6'd34; rb_addr = 6'd8; #1;
        total++; if (bus_a !== 32'h1234 || bus_b !== 32'hA5) begin
            $display("FAIL zero_side_effect got=%h/%h want=00001234/000000a5", bus_a, bus_b); bad++; end
        ra_addr = 6'd1; rb_addr = 6'd37; #1;
        total++; if (bus_a !== 32'h0 || bus_b !== 32'h0 || ir !== 32'h0) begin
            $display("FAIL zero_side_effect2 got=%h/%h/%h want=0/0/0", bus_a, bus_b, ir); bad++; end
    endtask

    task automatic test_special();
        wr_en = 1; rc_addr = 6'd37; wr_data = 32'hCAFE_0001; tick();
        rc_addr = 6'd32; wr_data = 32'h0000_0400; tick();
        rc_addr = 6'd7;  wr_data = 32'h0000_0707; tick();
        wr_en = 0;
        ra_addr = 6'd32; rb_addr = 6'd7; #1;
        total++; if (ir !== 32'hCAFE_0001) begin $display("FAIL ir_out got=%h want=cafe0001", ir); bad++; end
        total++; if (bus_a !== 32'h400 || bus_b !== 32'h707) begin
            $display("FAIL pc_global got=%h/%h want=00000400/00000707", bus_a, bus_b); bad++; end
    endtask

    task automatic test_simultaneous();
        save = 1; restore = 1; tick();
        save = 0; restore = 0;
        total++; if (cwp !== 2'd0 || ovf_trap !== 1'b0 || unf_trap !== 1'b0) begin
            $display("FAIL save_restore got cwp=%0d traps=%b%b want cwp=0 traps=00", cwp, ovf_trap, unf_trap); bad++; end
        save = 1; wr_en = 1; rc_addr = 6'd16; wr_data = 32'hBEEF; tick();
        save = 0; wr_en = 0; ra_addr = 6'd16; #1;
        total++; if (cwp !== 2'd1 || bus_a !== 32'h0) begin
            $display("FAIL save_write_w1 got cwp=%0d data=%h want cwp=1 data=0", cwp, bus_a); bad++; end
        restore = 1; tick();
        restore = 0; #1;
        total++; if (cwp !== 2'd0 || bus_a !== 32'hBEEF) begin
            $display("FAIL save_write_w0 got cwp=%0d data=%h want cwp=0 data=0000beef", cwp, bus_a); bad++; end
        save = 1; tick();
        win_clr = 1; tick();
        save = 0; win_clr = 0;
        total++; if (cwp !== 2'd0 || ovf_trap !== 1'b0) begin
            $display("FAIL winclr_save got cwp=%0d ovf=%b want cwp=0 ovf=0", cwp, ovf_trap); bad++; end
    endtask

    task automatic test_reset_trap();
        save = 1; tick(); tick(); tick();
        save = 0;
        total++; if (ovf_trap !== 1'b1) begin $display("FAIL pre_reset_ovf got=%b want=1", ovf_trap); bad++; end
        #2 rst = 0;
        #1;
        total++; if (ovf_trap !== 1'b0 || cwp !== 2'd0) begin
            $display("FAIL reset_kills_trap got ovf=%b cwp=%0d want ovf=0 cwp=0", ovf_trap, cwp); bad++; end
        ra_addr = 6'd34; #1;
        total++; if (bus_a !== 32'h0) begin $display("FAIL reset_clears_temp got=%h want=0", bus_a); bad++; end
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        tick(); tick();
        @(negedge clk);
        rst = 1;
        tick();
        test_reset();
        idle_inputs();
        test_overlap();
        idle_inputs();
        test_overflow();
        idle_inputs();
        test_bypass();
        idle_inputs();
        test_zero_unmapped();
        idle_inputs();
        test_special();
        idle_inputs();
        test_simultaneous();
        idle_inputs();
        test_reset_trap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
